// File: rtl/kick_controller.sv
// kick_controller
//
// Turns the kick-decision bit (kick_req) into a single solenoid pulse.
// kick_req must be high for CONFIRM consecutive edges before a pulse fires.
// The pulse lasts PULSE cycles and is followed by a COOLDOWN lockout.
// After a pulse starts, kick_req must be seen low at least once before
// another kick is allowed (re-arm).
//
// Ports
//   clk         in   1  system clock, rising edge
//   rst         in   1  synchronous reset, active-high
//   enable      in   1  1 = kicking allowed; 0 = abort/inhibit
//   kick_req    in   1  decision bit from the kick-decision logic
//   kick_out    out  1  solenoid drive, high only in FIRE
//   busy        out  1  high whenever state != IDLE
//   state       out  2  IDLE=0, CONFIRM=1, FIRE=2, COOL=3 (debug)
//   kick_count  out  8  pulses started, saturates at 255
//
// Handshake: none. kick_req is a level that is sampled on every rising
// edge. There is no valid/ready pair and no back-pressure.
module kick_controller #(
  parameter int CONFIRM  = 4,
  parameter int PULSE    = 8,
  parameter int COOLDOWN = 16,
  parameter int CW       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       kick_req,
  output logic       kick_out,
  output logic       busy,
  output logic [1:0] state,
  output logic [7:0] kick_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONFIRM = 2'd1,
    S_FIRE    = 2'd2,
    S_COOL    = 2'd3
  } state_t;

  localparam logic [CW-1:0] CONF_LAST  = CW'(CONFIRM - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE - 1);
  localparam logic [CW-1:0] COOL_LAST  = CW'(COOLDOWN - 1);

  state_t        st;
  logic [CW-1:0] cnt;
  logic          armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= S_IDLE;
      cnt        <= '0;
      armed      <= 1'b1;
      kick_count <= 8'd0;
    end else begin
      // Re-arm on any low sample. The FIRE-entry clear below comes later
      // in this block, so it wins when both happen on the same edge.
      if (!kick_req) armed <= 1'b1;

      case (st)
        S_IDLE: begin
          if (enable && kick_req && armed) begin
            st  <= S_CONFIRM;
            cnt <= CW'(1);
          end
        end

        S_CONFIRM: begin
          if (!enable || !kick_req) begin
            st  <= S_IDLE;
            cnt <= '0;
          end else if (cnt == CONF_LAST) begin
            st    <= S_FIRE;
            cnt   <= '0;
            armed <= 1'b0;
            if (kick_count != 8'hFF) kick_count <= kick_count + 8'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_FIRE: begin
          // Dropping enable truncates the pulse and goes straight to COOL.
          if (!enable || cnt == PULSE_LAST) begin
            st  <= S_COOL;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_COOL: begin
          if (cnt == COOL_LAST) begin
            st  <= S_IDLE;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          st  <= S_IDLE;
          cnt <= '0;
        end
      endcase
    end
  end

  // Every output is decoded from registers only. There is no path from
  // any input to any output.
  assign state    = st;
  assign kick_out = (st == S_FIRE);
  assign busy     = (st != S_IDLE);

endmodule

// File: tb/tb_kick_controller.sv
// tb_kick_controller
//
// Directed scenarios and random stimulus for kick_controller. Each is checked
// on every cycle against a timer-based reference model. The model tracks how
// many pulse and lockout cycles remain and how long the confirm run is.
module tb_kick_controller;

  localparam int CONFIRM  = 4;
  localparam int PULSE    = 8;
  localparam int COOLDOWN = 16;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       kick_req;
  logic       kick_out;
  logic       busy;
  logic [1:0] state;
  logic [7:0] kick_count;

  always #5 clk = ~clk;

  kick_controller #(
    .CONFIRM (CONFIRM),
    .PULSE   (PULSE),
    .COOLDOWN(COOLDOWN),
    .CW      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .kick_req  (kick_req),
    .kick_out  (kick_out),
    .busy      (busy),
    .state     (state),
    .kick_count(kick_count)
  );

  // ---------------- counters / scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  // Pulse numbers that the model expects kick_count to show when each pulse rises.
  logic [7:0] exp_q[$];

  // Reference model state
  int fire_left = 0;   // pulse cycles still to show
  int cool_left = 0;   // lockout cycles still to show
  int run_len   = 0;   // accepted consecutive highs in the current confirm run
  int m_armed   = 1;
  int m_count   = 0;

  // Per-scenario observations
  logic prev_kick   = 1'b0;
  int   rises       = 0;
  int   high_cycles = 0;
  int   cool_cycles = 0;

  logic [7:0] f_tab = 8'b1110_0100;  // kick decision y = f(x): x in {2,5,6,7}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic e, input logic q);
    logic fired;
    fired = 1'b0;
    if (r) begin
      fire_left = 0; cool_left = 0; run_len = 0; m_armed = 1; m_count = 0;
      exp_q.delete();
    end else begin
      if (fire_left > 0) begin
        if (!e || fire_left == 1) begin
          fire_left = 0;
          cool_left = COOLDOWN;
        end else begin
          fire_left--;
        end
      end else if (cool_left > 0) begin
        cool_left--;
      end else if (run_len > 0) begin
        if (!e || !q) run_len = 0;
        else if (run_len + 1 == CONFIRM) begin
          run_len   = 0;
          fire_left = PULSE;
          fired     = 1'b1;
          if (m_count < 255) m_count++;
          exp_q.push_back(8'(m_count));
        end else begin
          run_len++;
        end
      end else if (e && q && m_armed != 0) begin
        run_len = 1;
      end
      if (fired) m_armed = 0;
      else if (!q) m_armed = 1;
    end
  endtask

  function automatic int exp_state();
    if (fire_left > 0) return 2;
    if (cool_left > 0) return 3;
    if (run_len > 0)   return 1;
    return 0;
  endfunction

  // ---------------- driver ----------------
  task automatic tick(input logic r, input logic e, input logic q);
    rst = r; enable = e; kick_req = q;
    @(posedge clk);
    model_edge(r, e, q);
    #1;
    check("state",      32'(state),      32'(exp_state()));
    check("kick_out",   32'(kick_out),   32'(fire_left > 0));
    check("busy",       32'(busy),       32'(exp_state() != 0));
    check("kick_count", 32'(kick_count), 32'(m_count));
    if (kick_out && !prev_kick) begin
      rises++;
      check("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("pulse_number", 32'(kick_count), 32'(exp_q.pop_front()));
    end
    if (kick_out) high_cycles++;
    if (state == 2'd3) cool_cycles++;
    prev_kick = kick_out;
  endtask

  task automatic clear_obs();
    rises = 0; high_cycles = 0; cool_cycles = 0;
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] pat3 = 8'b1111_0111;  // applied LSB first: 1,1,1,0,1,1,1,1

  initial begin
    rst = 1'b1; enable = 1'b0; kick_req = 1'b0;

    // 1. reset
    tick(1, 0, 0);
    tick(1, 0, 0);
    check("rst_state",      32'(state),      32'd0);
    check("rst_kick_out",   32'(kick_out),   32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_kick_count", 32'(kick_count), 32'd0);

    // 2. held request: one kick only
    clear_obs();
    for (int i = 0; i < 30; i++) tick(0, 1, 1);
    check("s2_high_cycles", 32'(high_cycles), 32'(PULSE));
    check("s2_cool_cycles", 32'(cool_cycles), 32'(COOLDOWN));
    check("s2_rises",       32'(rises),       32'd1);
    check("s2_kick_count",  32'(kick_count),  32'd1);

    // 3. glitch restarts the confirm run
    clear_obs();
    tick(0, 1, 0);
    for (int i = 0; i < 8; i++) tick(0, 1, pat3[i]);
    check("s3_state_fire", 32'(state), 32'd2);
    for (int i = 0; i < 30; i++) tick(0, 1, 0);
    check("s3_rises",       32'(rises),       32'd1);
    check("s3_high_cycles", 32'(high_cycles), 32'(PULSE));

    // 4. enable dropped on 3rd FIRE cycle
    clear_obs();
    for (int i = 0; i < 4; i++) tick(0, 1, 1);
    tick(0, 1, 1);
    tick(0, 1, 1);
    tick(0, 0, 1);
    check("s4_abort_kick_out", 32'(kick_out), 32'd0);
    for (int i = 0; i < 16; i++) tick(0, 0, 0);
    check("s4_high_cycles", 32'(high_cycles), 32'd3);
    check("s4_cool_cycles", 32'(cool_cycles), 32'(COOLDOWN));
    check("s4_idle",        32'(state),       32'd0);

    // 5. toggling request during FIRE/COOL, then a fresh kick
    clear_obs();
    tick(0, 1, 0);
    for (int i = 0; i < 4; i++) tick(0, 1, 1);
    for (int i = 0; i < 24; i++) tick(0, 1, logic'(i[0]));
    check("s5_idle_after_cool", 32'(state), 32'd0);
    for (int i = 0; i < 3; i++) tick(0, 1, 1);
    check("s5_confirming", 32'(state), 32'd1);
    tick(0, 1, 1);
    check("s5_second_fire", 32'(kick_out), 32'd1);
    tick(0, 1, 1);
    tick(0, 1, 1);
    check("s5_rises", 32'(rises), 32'd2);
    for (int i = 0; i < 30; i++) tick(0, 1, 0);

    // 6. reset mid-FIRE, then sweep the decision inputs
    for (int i = 0; i < 6; i++) tick(0, 1, 1);
    tick(1, 1, 1);
    check("s6_rst_kick_out",   32'(kick_out),   32'd0);
    check("s6_rst_state",      32'(state),      32'd0);
    check("s6_rst_kick_count", 32'(kick_count), 32'd0);
    for (int x = 0; x < 8; x++) begin
      clear_obs();
      for (int i = 0; i < 30; i++) tick(0, 1, f_tab[x]);
      tick(0, 1, 0);
      tick(0, 1, 0);
      check($sformatf("s6_x%0d_rises", x), 32'(rises), 32'(f_tab[x]));
    end

    // random stimulus
    for (int i = 0; i < 600; i++) begin
      logic e, q;
      e = ($urandom_range(0, 9) != 0);
      q = ($urandom_range(0, 5) == 0) ? ~kick_req : kick_req;
      tick(0, e, q);
    end

    // saturation of kick_count
    tick(1, 0, 0);
    clear_obs();
    for (int k = 0; k < 260; k++) begin
      for (int i = 0; i < CONFIRM + PULSE + COOLDOWN; i++) tick(0, 1, 1);
      tick(0, 1, 0);
    end
    check("sat_kick_count", 32'(kick_count), 32'd255);
    check("sat_rises",      32'(rises),      32'd260);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
